disp_frame_arb: RTL

Display frame arbiter and commit controller. Owns the 256-bit frame (8 × 32-bit words) presented on `disp_data` to the display shift register. Shares that frame between two requesters: requester 0 is the time/digit formatter, requester 1 is the CPU register path. Each requester builds a frame through a req/gnt word-write handshake. Completed frames are committed atomically, never on a `tsc_1ppms` cycle, so the shift register's millisecond frame load always sees a whole, stable frame.

---
 rtl/disp_frame_arb_if.sv | 28 ++
 rtl/disp_frame_arb.sv | 122 ++++++++++++
 2 files changed

// File: rtl/disp_frame_arb_if.sv
// Requester-side bundle for the display frame arbiter:
// frame request/grant plus one word-write port per requester.
interface disp_frame_arb_if;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        wr0_en;
    logic [2:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr0_last;
    logic        wr1_en;
    logic [2:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        wr1_last;

    modport master (
        output req,
        output wr0_en, output wr0_addr, output wr0_data, output wr0_last,
        output wr1_en, output wr1_addr, output wr1_data, output wr1_last,
        input  gnt
    );

    modport slave (
        input  req,
        input  wr0_en, input wr0_addr, input wr0_data, input wr0_last,
        input  wr1_en, input wr1_addr, input wr1_data, input wr1_last,
        output gnt
    );
endinterface

// File: rtl/disp_frame_arb.sv
// Display frame arbiter: two requesters build frames in a shadow
// copy; finished frames commit atomically, never on a ms tick.
module disp_frame_arb #(
    parameter int TIMEOUT_US = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tsc_1ppms,
    input  logic                 tsc_1ppus,
    input  logic                 blank,
    disp_frame_arb_if.slave      bus,
    output logic [255:0]         disp_data,
    output logic                 commit,
    output logic                 err_timeout
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, PEND} state_t;

    state_t           state;
    state_t           state_nx;
    logic [7:0][31:0] frame_q;
    logic [7:0][31:0] shadow;
    logic [7:0][31:0] frame_d;
    logic             last_gnt;
    logic             sel_q;
    logic             sel_d;
    logic [7:0]       cnt;
    logic             wr_en;
    logic             wr_last;
    logic [2:0]       wr_addr;
    logic [31:0]      wr_data;
    logic             req_s;
    logic             timeout;
    logic             wr_ok;

    // Route the granted requester's write port and request level
    always_comb begin
        wr_en   = sel_q ? bus.wr1_en   : bus.wr0_en;
        wr_last = sel_q ? bus.wr1_last : bus.wr0_last;
        wr_addr = sel_q ? bus.wr1_addr : bus.wr0_addr;
        wr_data = sel_q ? bus.wr1_data : bus.wr0_data;
        req_s   = bus.req[sel_q];
    end

    // Lone request wins; a tie goes to whoever was not granted last
    assign sel_d   = (bus.req == 2'b11) ? ~last_gnt : bus.req[1];
    assign timeout = (cnt == 8'(TIMEOUT_US));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state; a last write outranks both abort causes
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (|bus.req) state_nx = LOAD;
            LOAD:  state_nx = WRITE;
            WRITE: begin
                if (wr_en && wr_last)     state_nx = PEND;
                else if (timeout || !req_s) state_nx = IDLE;
            end
            PEND:  if (!tsc_1ppms) state_nx = IDLE;
        endcase
    end

    // Per-state strobes: commit, timeout pulse, shadow write enable
    always_comb begin
        commit      = 1'b0;
        err_timeout = 1'b0;
        wr_ok       = 1'b0;
        unique case (state)
            WRITE: begin
                err_timeout = timeout && !(wr_en && wr_last);
                wr_ok       = wr_en && (wr_last || !timeout);
            end
            PEND:    commit = !tsc_1ppms;
            default: ;
        endcase
    end

    // Next committed frame, also feeds the output register directly
    assign frame_d = commit ? shadow : frame_q;

    // Grant, round-robin history, timeout counter and shadow frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= 1'b0;
            last_gnt <= 1'b1;
            bus.gnt  <= 2'b00;
            cnt      <= 8'd0;
            shadow   <= '0;
        end else begin
            if (state == IDLE) sel_q <= sel_d;
            if (state == LOAD) begin
                shadow   <= frame_q;
                bus.gnt  <= sel_q ? 2'b10 : 2'b01;
                last_gnt <= sel_q;
                cnt      <= 8'd0;
            end
            if (state == WRITE) begin
                if (wr_ok)     shadow[wr_addr] <= wr_data;
                if (tsc_1ppus) cnt <= cnt + 8'd1;
                if (state_nx != WRITE) bus.gnt <= 2'b00;
            end
        end
    end

    // Committed frame and blanked display output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q   <= '0;
            disp_data <= '0;
        end else begin
            frame_q   <= frame_d;
            disp_data <= blank ? '0 : frame_d;
        end
    end

endmodule
